// File: rtl/regfile_mp.sv
// Multi-port integer register file for the Decode stage.
// Rising-edge writes on NWR ports, combinational reads on NRD ports with
// optional write-to-read bypass, and a sequenced bulk-clear engine that
// zeroes one entry per cycle while busy is high.
module regfile_mp #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int NWR      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*XLEN-1:0]  wd,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*XLEN-1:0]  rd,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 wr_drop
);

    localparam int unsigned LAST = NREGS - 1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] mem [NREGS];
    logic [NWR-1:0]  wvalid;
    logic [NRD-1:0]  rvalid;

    // Address range checks; when NREGS is a power of two every address is valid.
    for (genvar gj = 0; gj < NWR; gj++) begin : g_wvalid
        if ((1 << AW) == NREGS) begin : g_full
            assign wvalid[gj] = 1'b1;
        end else begin : g_part
            assign wvalid[gj] = (wa[gj*AW +: AW] < AW'(NREGS));
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rvalid
        if ((1 << AW) == NREGS) begin : g_full
            assign rvalid[gi] = 1'b1;
        end else begin : g_part
            assign rvalid[gi] = (ra[gi*AW +: AW] < AW'(NREGS));
        end
    end

    assign busy = (state == CLEAR);

    // Clear FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Clear FSM next state: accept a request in IDLE, leave after the last entry.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (clr_req) state_n = CLEAR;
            CLEAR: if (idx == AW'(LAST)) state_n = IDLE;
        endcase
    end

    // Array, clear index and dropped-write flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            idx     <= '0;
            wr_drop <= 1'b0;
        end else if (state == CLEAR) begin
            mem[idx] <= '0;
            idx      <= idx + AW'(1);
            wr_drop  <= |we;
        end else begin
            // Ascending port order: the highest-index port's NBA lands last and wins.
            for (int unsigned j = 0; j < NWR; j++) begin
                if (we[j] && wvalid[j] &&
                    !(ZERO_REG != 0 && wa[j*AW +: AW] == '0)) begin
                    mem[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
                end
            end
            wr_drop <= |(we & ~wvalid);
            if (clr_req) begin
                idx <= '0;
            end
        end
    end

    // Combinational read with zero/out-of-range masking and optional bypass.
    always_comb begin
        rd = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (rvalid[i] && !(ZERO_REG != 0 && ra[i*AW +: AW] == '0)) begin
                rd[i*XLEN +: XLEN] = mem[ra[i*AW +: AW]];
                if (BYPASS != 0 && state == IDLE) begin
                    for (int unsigned j = 0; j < NWR; j++) begin
                        if (we[j] && wa[j*AW +: AW] == ra[i*AW +: AW]) begin
                            rd[i*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: two instances (bypass on / off) share
// all inputs and are compared against a behavioural register-file model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd, rd_nb;
    logic        clr_req;
    logic        busy, busy_nb;
    logic        wr_drop, wr_drop_nb;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_mem [32];
    bit          m_busy;
    int          m_idx;
    bit          m_drop;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
        .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_nb),
        .clr_req(clr_req), .busy(busy_nb), .wr_drop(wr_drop_nb)
    );

    // Model update for one rising edge, using the inputs currently applied.
    task automatic model_edge();
        if (rst) begin
            for (int k = 0; k < 32; k++) m_mem[k] = '0;
            m_busy = 0;
            m_idx  = 0;
            m_drop = 0;
        end else if (m_busy) begin
            m_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == 32) m_busy = 0;
            m_drop = (we != 2'b00);
        end else begin
            for (int j = 0; j < 2; j++)
                if (we[j] && wa[j*5 +: 5] != 5'd0) m_mem[wa[j*5 +: 5]] = wd[j*32 +: 32];
            m_drop = 0;
            if (clr_req) begin
                m_busy = 1;
                m_idx  = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = m_mem[a];
        if (byp && !m_busy)
            for (int j = 0; j < 2; j++)
                if (we[j] && wa[j*5 +: 5] == a) v = wd[j*32 +: 32];
        return v;
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; we = '0; wa = '0; wd = '0; clr_req = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout busy=%b required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1; we = 2'b11; wa = 10'($urandom); wd = {$urandom, $urandom}; clr_req = 1;
        cycle();
        idle_inputs();
        n_checks += 2;
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a ^ 31), 5'(a)};
            #1;
            n_checks += 4;
            if (rd[31:0] !== 32'd0)     begin n_fail++; $display("FAIL reset_rd0 a=%0d got=%h exp=0", a, rd[31:0]); end
            if (rd[63:32] !== 32'd0)    begin n_fail++; $display("FAIL reset_rd1 a=%0d got=%h exp=0", a ^ 31, rd[63:32]); end
            if (rd_nb[31:0] !== 32'd0)  begin n_fail++; $display("FAIL reset_nb_rd0 a=%0d got=%h exp=0", a, rd_nb[31:0]); end
            if (rd_nb[63:32] !== 32'd0) begin n_fail++; $display("FAIL reset_nb_rd1 a=%0d got=%h exp=0", a ^ 31, rd_nb[63:32]); end
        end
    endtask

    task automatic test_bypass();
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF}; ra = {5'd5, 5'd5};
        #1;
        n_checks += 2;
        if (rd[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle got=%h exp=deadbeef", rd[31:0]); end
        if (rd_nb[31:0] !== 32'd0)     begin n_fail++; $display("FAIL nobypass_old got=%h exp=0", rd_nb[31:0]); end
        cycle();
        we = '0;
        #1;
        n_checks += 2;
        if (rd[31:0] !== 32'hDEADBEEF)    begin n_fail++; $display("FAIL bypass_stored got=%h exp=deadbeef", rd[31:0]); end
        if (rd_nb[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobypass_next got=%h exp=deadbeef", rd_nb[63:32]); end
    endtask

    task automatic test_collision();
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11}; ra = {5'd7, 5'd7};
        #1;
        n_checks++;
        if (rd[31:0] !== 32'h22) begin n_fail++; $display("FAIL collision_bypass got=%h exp=22", rd[31:0]); end
        cycle();
        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'h33}; ra = {5'd7, 5'd0};
        cycle();
        we = '0;
        #1;
        n_checks += 4;
        if (rd[31:0] !== 32'd0)     begin n_fail++; $display("FAIL x0_read got=%h exp=0", rd[31:0]); end
        if (rd_nb[31:0] !== 32'd0)  begin n_fail++; $display("FAIL x0_read_nb got=%h exp=0", rd_nb[31:0]); end
        if (rd_nb[63:32] !== 32'h22) begin n_fail++; $display("FAIL collision_stored got=%h exp=22", rd_nb[63:32]); end
        if (wr_drop !== 1'b0)        begin n_fail++; $display("FAIL x0_wr_drop got=%b exp=0", wr_drop); end
    endtask

    task automatic test_clear();
        int cnt = 0;
        for (int k = 1; k < 32; k++) begin
            we = 2'b01; wa = {5'd0, 5'(k)}; wd = {32'd0, 32'(k)};
            cycle();
        end
        we = '0; clr_req = 1;
        cycle();
        clr_req = 0;
        while (busy === 1'b1 && cnt < 100) begin
            if (cnt == 16) begin
                ra = {5'd31, 5'd31};
                #1;
                n_checks += 2;
                if (rd[31:0] !== 32'd31)    begin n_fail++; $display("FAIL clear_mid_x31 got=%h exp=1f", rd[31:0]); end
                if (rd_nb[63:32] !== 32'd31) begin n_fail++; $display("FAIL clear_mid_x31_nb got=%h exp=1f", rd_nb[63:32]); end
            end
            cnt++;
            cycle();
        end
        n_checks++;
        if (cnt != 32) begin n_fail++; $display("FAIL clear_busy_len got=%0d exp=32", cnt); end
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a), 5'(a)};
            #1;
            n_checks += 2;
            if (rd[31:0] !== 32'd0)     begin n_fail++; $display("FAIL clear_after a=%0d got=%h exp=0", a, rd[31:0]); end
            if (rd_nb[63:32] !== 32'd0) begin n_fail++; $display("FAIL clear_after_nb a=%0d got=%h exp=0", a, rd_nb[63:32]); end
        end
    endtask

    task automatic test_write_during_clear();
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h77};
        cycle();
        we = '0; clr_req = 1;
        cycle();
        clr_req = 0;
        cycle();
        // busy cycle with idx=1: x3 still holds 0x77
        we = 2'b10; wa = {5'd3, 5'd0}; wd = {32'h55, 32'd0}; ra = {5'd3, 5'd3};
        #1;
        n_checks++;
        if (rd[31:0] !== 32'h77) begin n_fail++; $display("FAIL busy_no_bypass got=%h exp=77", rd[31:0]); end
        cycle();
        we = '0;
        #1;
        n_checks += 2;
        if (wr_drop !== 1'b1)   begin n_fail++; $display("FAIL busy_wr_drop got=%b exp=1", wr_drop); end
        if (rd[31:0] !== 32'h77) begin n_fail++; $display("FAIL busy_not_written got=%h exp=77", rd[31:0]); end
        cycle();
        n_checks++;
        if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL busy_wr_drop_pulse got=%b exp=0", wr_drop); end
        wait_idle("write_during_clear");
        n_checks++;
        if (rd[31:0] !== 32'd0) begin n_fail++; $display("FAIL busy_x3_cleared got=%h exp=0", rd[31:0]); end
    endtask

    task automatic test_reset_mid_clear();
        we = 2'b11; wa = {5'd20, 5'd25}; wd = {32'h1234, 32'h5678};
        cycle();
        we = '0; clr_req = 1;
        cycle();
        clr_req = 0;
        for (int k = 1; k < 10; k++) cycle();
        rst = 1;
        cycle();
        rst = 0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a), 5'(a)};
            #1;
            n_checks++;
            if (rd[31:0] !== 32'd0) begin n_fail++; $display("FAIL midrst_zero a=%0d got=%h exp=0", a, rd[31:0]); end
        end
        we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'd0, 32'h99};
        cycle();
        we = '0; ra = {5'd4, 5'd4};
        #1;
        n_checks += 2;
        if (rd[31:0] !== 32'h99)     begin n_fail++; $display("FAIL midrst_write got=%h exp=99", rd[31:0]); end
        if (rd_nb[63:32] !== 32'h99) begin n_fail++; $display("FAIL midrst_write_nb got=%h exp=99", rd_nb[63:32]); end
    endtask

    task automatic test_random();
        logic [4:0] a0, a1;
        for (int n = 0; n < 400; n++) begin
            we = 2'($urandom);
            for (int j = 0; j < 2; j++)
                wa[j*5 +: 5] = ($urandom % 2 == 0) ? 5'($urandom % 8) : 5'($urandom);
            wd = {$urandom, $urandom};
            a0 = ($urandom % 2 == 0) ? wa[4:0] : 5'($urandom);
            a1 = ($urandom % 2 == 0) ? wa[9:5] : 5'($urandom % 8);
            ra = {a1, a0};
            clr_req = ($urandom % 40 == 0);
            #1;
            n_checks += 8;
            if (rd[31:0] !== exp_rd(a0, 1))     begin n_fail++; $display("FAIL rand_rd0 n=%0d a=%0d got=%h exp=%h", n, a0, rd[31:0], exp_rd(a0, 1)); end
            if (rd[63:32] !== exp_rd(a1, 1))    begin n_fail++; $display("FAIL rand_rd1 n=%0d a=%0d got=%h exp=%h", n, a1, rd[63:32], exp_rd(a1, 1)); end
            if (rd_nb[31:0] !== exp_rd(a0, 0))  begin n_fail++; $display("FAIL rand_nb_rd0 n=%0d a=%0d got=%h exp=%h", n, a0, rd_nb[31:0], exp_rd(a0, 0)); end
            if (rd_nb[63:32] !== exp_rd(a1, 0)) begin n_fail++; $display("FAIL rand_nb_rd1 n=%0d a=%0d got=%h exp=%h", n, a1, rd_nb[63:32], exp_rd(a1, 0)); end
            if (busy !== m_busy)       begin n_fail++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, m_busy); end
            if (busy_nb !== m_busy)    begin n_fail++; $display("FAIL rand_busy_nb n=%0d got=%b exp=%b", n, busy_nb, m_busy); end
            if (wr_drop !== m_drop)    begin n_fail++; $display("FAIL rand_wr_drop n=%0d got=%b exp=%b", n, wr_drop, m_drop); end
            if (wr_drop_nb !== m_drop) begin n_fail++; $display("FAIL rand_wr_drop_nb n=%0d got=%b exp=%b", n, wr_drop_nb, m_drop); end
            cycle();
        end
        idle_inputs();
        wait_idle("random");
    endtask

    initial begin
        idle_inputs();
        ra = '0;
        rst = 1;
        test_reset();
        test_bypass();
        test_collision();
        test_clear();
        test_write_during_clear();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
